div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
- Driven by the decoded ALU control and operands from the ID/EX pipeline register.
- Holds the execute stage stalled through its stall request until the quotient and remainder are ready.
- The datapath writes the result to HI/LO under hilo_we: HI = remainder, LO = quotient.

Parameters:
- DATA_W, 32, operand width; iteration count = DATA_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  divide requested; held high by the datapath until ready_o
- signed_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i in IDLE
- opa_i  input  DATA_W  dividend (rs); sampled in IDLE
- opb_i  input  DATA_W  divisor (rt); sampled in IDLE
- annul_i  input  1  flushE / exception; abort operation
- result_o  output  2*DATA_W  {remainder, quotient}
- ready_o  output  1  result valid, one-cycle pulse
- stall_o  output  1  execute-stage stall request

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset: state = IDLE, counter = 0, result_o = 0, ready_o = 0, all internal registers = 0.
- stall_o = start_i & ~ready_o & ~annul_i (combinational).
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - start_i=1, annul_i=0, opb_i=0 -> DIVZERO.
  - start_i=1, annul_i=0, opb_i!=0 -> ON. Latch operand magnitudes: for signed_i, take the two's-complement negation of a negative operand. Latch quot_neg = signed_i & (opa_i[MSB] ^ opb_i[MSB]) and rem_neg = signed_i & opa_i[MSB]. Clear the partial remainder and counter to 0.
  - Otherwise remain in IDLE.
- ON, per cycle:
  - Shift {partial_rem, dividend} left by 1.
  - Trial-subtract the divisor from the DATA_W+1-bit partial remainder.
  - If non-negative, keep the difference and set quotient bit 1; else restore and set quotient bit 0.
  - counter increments; after the DATA_W-th iteration (counter = DATA_W-1 at the edge) -> DONE.
  - On that edge, register final signs: quotient negated if quot_neg, remainder negated if rem_neg.
- DIVZERO: one cycle, then DONE with result = 0 (both halves).
- DONE:
  - ready_o = 1 and result_o valid this cycle only; next state IDLE unconditionally.
  - result_o holds its value in IDLE until the next DONE.
- Latency: start accepted at edge N -> ON cycles N+1..N+DATA_W -> DONE (ready_o=1) at cycle N+DATA_W+1 (33 for DATA_W=32). Divide-by-zero: ready_o at N+2.
- Back-to-back: start_i high in the cycle after DONE is accepted as a new operation. No operation is accepted while ready_o=1, because the state is DONE, not IDLE.
- annul_i:
  - In any non-IDLE state -> IDLE next edge; ready_o not asserted for the aborted operation; result_o unchanged.
  - In IDLE, annul_i blocks acceptance.
  - annul_i has priority over start_i.
- Operands changing during ON are ignored; only values latched in IDLE are used.
- Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0 (modulo wrap; no exception).
- rst mid-operation: IDLE next edge, outputs cleared per reset values.
- Sign rule: quotient truncates toward zero; remainder takes the dividend's sign. Unsigned mode never negates.

Test Plan:
- DIVU 100/7: start at cycle N -> ready_o=1 exactly at N+33, result_o = {0x00000002, 0x0000000E}; stall_o high N..N+32, low at N+33.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU with the same bits -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero (opa=0x1234, opb=0): ready_o at N+2, result_o = 0. Then DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000} at N+33.
- annul_i pulsed at N+10 during ON -> IDLE at N+11, ready_o stays 0 through N+40, result_o retains previous value. A new DIVU 9/3 started afterwards -> {0, 3} with full 33-cycle latency.
- rst asserted at N+5 mid-division -> all outputs 0 next cycle, state IDLE. Back-to-back DIVU 0xFFFFFFFF/1 then 10/3 (start re-asserted the cycle after DONE) -> two ready pulses 34 cycles apart with {0, 0xFFFFFFFF} then {1, 3}.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} after DATA_W iterations; holds the stage stalled meanwhile.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opa_i,
    input  logic [DATA_W-1:0]     opb_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stall_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      counter_r;
    logic [DATA_W-1:0]     dividend_r;
    logic [DATA_W-1:0]     divisor_r;
    logic [DATA_W-1:0]     prem_r;
    logic                  quot_neg_r;
    logic                  rem_neg_r;
    logic [2*DATA_W-1:0]   result_r;
    logic                  ready_r;

    logic [DATA_W:0]       shift_s;
    logic [DATA_W:0]       trial_s;
    logic [DATA_W-1:0]     rem_next_s;
    logic [DATA_W-1:0]     quot_next_s;
    logic                  a_neg_s;
    logic                  b_neg_s;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                      input logic neg);
        return neg ? negate(v) : v;
    endfunction

    // Next-state selection and one restoring-division step
    always_comb begin
        state_s = state_r;
        a_neg_s = signed_i & opa_i[DATA_W-1];
        b_neg_s = signed_i & opb_i[DATA_W-1];
        shift_s = {prem_r, dividend_r[DATA_W-1]};
        trial_s = shift_s - {1'b0, divisor_r};
        // A borrow out of the trial subtraction means the divisor did not fit
        if (trial_s[DATA_W]) begin
            rem_next_s  = shift_s[DATA_W-1:0];
            quot_next_s = {dividend_r[DATA_W-2:0], 1'b0};
        end else begin
            rem_next_s  = trial_s[DATA_W-1:0];
            quot_next_s = {dividend_r[DATA_W-2:0], 1'b1};
        end
        case (state_r)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opb_i == ZERO_W) begin
                        state_s = DIVZERO;
                    end else begin
                        state_s = ON;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_s = IDLE;
                end else if (counter_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = ON;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration registers and registered result/ready
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r  <= {CNT_W{1'b0}};
            dividend_r <= ZERO_W;
            divisor_r  <= ZERO_W;
            prem_r     <= ZERO_W;
            quot_neg_r <= 1'b0;
            rem_neg_r  <= 1'b0;
            result_r   <= {(2*DATA_W){1'b0}};
            ready_r    <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (state_s == ON) begin
                        dividend_r <= cond_negate(opa_i, a_neg_s);
                        divisor_r  <= cond_negate(opb_i, b_neg_s);
                        prem_r     <= ZERO_W;
                        counter_r  <= {CNT_W{1'b0}};
                        quot_neg_r <= a_neg_s ^ b_neg_s;
                        rem_neg_r  <= a_neg_s;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        prem_r     <= rem_next_s;
                        dividend_r <= quot_next_s;
                        counter_r  <= counter_r + CNT_ONE;
                        if (counter_r == CNT_LAST) begin
                            result_r <= {cond_negate(rem_next_s, rem_neg_r),
                                         cond_negate(quot_next_s, quot_neg_r)};
                            ready_r  <= 1'b1;
                        end
                    end
                end
                DIVZERO: begin
                    if (!annul_i) begin
                        result_r <= {(2*DATA_W){1'b0}};
                        ready_r  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;
    // Stall drops in the result cycle so the datapath can capture HI/LO and move on
    assign stall_o  = start_i & ~ready_r & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized bench for div_unit against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int checks;
    int failures;
    logic [63:0] last_res;

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic truncates toward zero, remainder follows dividend
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (n) tick();
    endtask

    // Start an operation in the current cycle and follow it to its ready pulse
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int lat, input string tag);
        start_i = 1'b1; annul_i = 1'b0;
        opa_i = a; opb_i = b; signed_i = sgn;
        #1;
        chk({tag, " stall@N"}, {63'd0, stall_o}, 64'd1);
        for (int c = 1; c <= lat; c++) begin
            tick();
            opa_i = $urandom; opb_i = $urandom; signed_i = 1'($urandom_range(0, 1));
            #1;
            if (c < lat) begin
                chk({tag, " ready_early"}, {63'd0, ready_o}, 64'd0);
                chk({tag, " stall_mid"}, {63'd0, stall_o}, 64'd1);
            end else begin
                chk({tag, " ready"}, {63'd0, ready_o}, 64'd1);
                chk({tag, " result"}, result_o, exp);
                chk({tag, " stall_done"}, {63'd0, stall_o}, 64'd0);
            end
        end
        last_res = exp;
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        checks = 0; failures = 0; last_res = 64'd0;
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opa_i = 32'd0; opb_i = 32'd0;
        repeat (2) tick();
        chk("reset result", result_o, 64'd0);
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset stall", {63'd0, stall_o}, 64'd0);
        rst = 1'b0;
        tick();

        do_op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, "divu_100_7");
        tick();
        chk("result_hold_idle", result_o, {32'h2, 32'hE});
        chk("ready_pulse_once", {63'd0, ready_o}, 64'd0);
        idle(1);
        do_op(32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2");
        idle(1);
        do_op(32'hFFFFFFF9, 32'h2, 1'b0, {32'h00000001, 32'h7FFFFFFC}, 33, "divu_m7_2");
        idle(1);
        do_op(32'h1234, 32'h0, 1'b0, 64'd0, 2, "divzero");
        idle(1);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "div_ovf");
        idle(1);

        // annul in ON: no ready for the aborted op, result retained
        start_i = 1'b1; opa_i = 32'd50; opb_i = 32'd5; signed_i = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        annul_i = 1'b1;
        #1;
        chk("annul stall", {63'd0, stall_o}, 64'd0);
        tick();
        annul_i = 1'b0; start_i = 1'b0;
        for (int c = 11; c <= 40; c++) begin
            #1;
            chk("annul no_ready", {63'd0, ready_o}, 64'd0);
            chk("annul result_kept", result_o, last_res);
            tick();
        end
        do_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "divu_9_3");
        idle(1);

        // annul in IDLE blocks acceptance (a divide-by-zero would otherwise pulse at +2)
        start_i = 1'b1; annul_i = 1'b1; opa_i = 32'd5; opb_i = 32'd0;
        #1;
        chk("idle_annul stall", {63'd0, stall_o}, 64'd0);
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        repeat (3) begin
            chk("idle_annul no_ready", {63'd0, ready_o}, 64'd0);
            tick();
        end

        // synchronous reset mid-division
        start_i = 1'b1; opa_i = 32'd1000; opb_i = 32'd3; signed_i = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("midrst result", result_o, 64'd0);
        chk("midrst ready", {63'd0, ready_o}, 64'd0);
        chk("midrst stall", {63'd0, stall_o}, 64'd0);
        tick();
        do_op(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, "divu_after_rst");

        // back-to-back: next start in the cycle right after DONE
        tick();
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "b2b_first");
        tick();
        do_op(32'd10, 32'd3, 1'b0, {32'd1, 32'd3}, 33, "b2b_second");
        idle(1);

        // randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 6)
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if (i % 8 == 3) a = 32'h80000000;
            sgn = 1'($urandom_range(0, 1));
            do_op(a, b, sgn, ref_div(a, b, sgn), (b == 32'd0) ? 2 : 33, "random");
            if (i % 2 == 1) idle(1);
            else tick();
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
